// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - radix-2 shift-add 32x32->64 MULT/MULTU sequencer on a shared adder
// One partial product per clock; sign handled by magnitude in, conditional negate out.
module mult_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  SIGNED_OP,
  input  logic [DATA_WIDTH-1:0] OPERAND_A,
  input  logic [DATA_WIDTH-1:0] OPERAND_B,
  output logic [DATA_WIDTH-1:0] ADD_IN_1,
  output logic [DATA_WIDTH-1:0] ADD_IN_2,
  input  logic [DATA_WIDTH-1:0] ADD_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int MSB = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0]   ONE_W  = DATA_WIDTH'(1);
  localparam logic [2*DATA_WIDTH-1:0] ONE_2W = (2 * DATA_WIDTH)'(1);
  localparam logic [CNT_WIDTH-1:0]    LAST   = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0]    cnt;
  logic [DATA_WIDTH-1:0]   mcand;
  logic [DATA_WIDTH-1:0]   p_hi;
  logic [DATA_WIDTH-1:0]   p_lo;
  logic                    neg;
  logic [DATA_WIDTH-1:0]   hi_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic                    done_q;

  logic [DATA_WIDTH-1:0]   abs_a;
  logic [DATA_WIDTH-1:0]   abs_b;
  logic                    carry;
  logic [2*DATA_WIDTH-1:0] product;
  logic [2*DATA_WIDTH-1:0] product_neg;

  // Magnitudes use a local negate so the shared adder stays free while idle.
  assign abs_a = OPERAND_A[MSB] ? (~OPERAND_A + ONE_W) : OPERAND_A;
  assign abs_b = OPERAND_B[MSB] ? (~OPERAND_B + ONE_W) : OPERAND_B;

  // The shared adder exposes no carry-out, so rebuild it from the operand and sum MSBs.
  assign carry = (ADD_IN_1[MSB] & ADD_IN_2[MSB]) |
                 ((ADD_IN_1[MSB] ^ ADD_IN_2[MSB]) & ~ADD_OUT[MSB]);

  assign product     = {p_hi, p_lo};
  assign product_neg = ~product + ONE_2W;

  assign BUSY = (state != S_IDLE);
  assign DONE = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ADD_IN_1  = '0;
    ADD_IN_2  = '0;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_nxt = S_ITER;
        end
      end
      S_ITER: begin
        ADD_IN_1 = p_hi;
        ADD_IN_2 = p_lo[0] ? mcand : '0;
        if (cnt == LAST) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt    <= '0;
      mcand  <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      neg    <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (START) begin
            cnt   <= '0;
            mcand <= SIGNED_OP ? abs_a : OPERAND_A;
            p_lo  <= SIGNED_OP ? abs_b : OPERAND_B;
            p_hi  <= '0;
            neg   <= SIGNED_OP & (OPERAND_A[MSB] ^ OPERAND_B[MSB]);
          end
        end
        S_ITER: begin
          {p_hi, p_lo} <= {carry, ADD_OUT, p_lo[MSB:1]};
          cnt          <= cnt + CNT_WIDTH'(1);
        end
        S_FIX: begin
          {hi_q, lo_q} <= neg ? product_neg : product;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
